rtype_fetch_ctrl: RTL

Instruction fetch, decode and phase-sequencing stage for the R-type datapath. It holds the PC and instruction register and fetches 32-bit words from an external combinational instruction ROM. It decodes RV32I R-type instructions into register addresses and a 4-bit ALU opcode, and steps a 4-phase FSM that produces one-cycle enables for the downstream register-read, ALU-flag and write-back stages. Those enables replace the separate phase clocks previously hand-driven on the register/ALU top.

---
 rtl/rtype_fetch_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/rtype_fetch_ctrl.sv
// rtype_fetch_ctrl: PC/IR fetch, RV32I R-type decode and a 4-phase
// IF/ID/EX/WB sequencer driving one-cycle stage enables.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   step, run       start one instruction (IDLE) / free-run select (WB)
//   inst_data       combinational ROM word at inst_addr
//   inst_addr       byte address = PC, word aligned
//   R_Addr_A/B      rs1 / rs2 fields of IR
//   W_Addr, ALU_OP  rd field, {IR[30], funct3}
//   en_RR/en_F      register-read (ID) / ALU capture (EX) enables
//   en_WB           write-back phase enable (WB)
//   Reg_Write       register-file write strobe (WB, legal, rd != 0)
//   busy, illegal   sequencing in progress / sticky illegal flag
module rtype_fetch_ctrl #(
    parameter int IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic        run,
    input  logic [31:0] inst_data,
    output logic [31:0] inst_addr,
    output logic [4:0]  R_Addr_A,
    output logic [4:0]  R_Addr_B,
    output logic [4:0]  W_Addr,
    output logic [3:0]  ALU_OP,
    output logic        en_RR,
    output logic        en_F,
    output logic        en_WB,
    output logic        Reg_Write,
    output logic        busy,
    output logic        illegal
);

    // PC is held as a word index so the byte address wraps for free.
    localparam int PCW = $clog2(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_ID,
        S_EX,
        S_WB,
        S_HALT
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [PCW-1:0] pc;
    logic [31:0]    ir;
    logic           ill_q;
    logic           legal;

    always_comb begin
        legal = 1'b0;
        if (ir[6:0] == 7'b0110011) begin
            unique case (1'b1)
                (ir[31:25] == 7'b0000000):
                    legal = 1'b1;
                (ir[31:25] == 7'b0100000):
                    legal = (ir[14:12] == 3'b000) ||
                            (ir[14:12] == 3'b101);
                default:
                    legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (step) state_nx = S_IF;
            S_IF:   state_nx = S_ID;
            S_ID:   state_nx = legal ? S_EX : S_HALT;
            S_EX:   state_nx = S_WB;
            S_WB:   state_nx = run ? S_IF : S_IDLE;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IF)
                ir <= inst_data;
            if (state == S_WB)
                pc <= pc + PCW'(1);
            if (state == S_ID && !legal)
                ill_q <= 1'b1;
        end
    end

    assign inst_addr = {{(30 - PCW){1'b0}}, pc, 2'b00};
    assign R_Addr_A  = ir[19:15];
    assign R_Addr_B  = ir[24:20];
    assign W_Addr    = ir[11:7];
    assign ALU_OP    = {ir[30], ir[14:12]};

    // Enables come only from the state register, so they are one-hot
    // and glitch-free with respect to step/run/inst_data.
    assign en_RR     = (state == S_ID);
    assign en_F      = (state == S_EX);
    assign en_WB     = (state == S_WB);
    assign Reg_Write = (state == S_WB) && legal && (ir[11:7] != 5'd0);
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign illegal   = ill_q;

endmodule
